// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the arbiter and the FIFO.
// The master modport is the arbiter's view; slave is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_ready;

  modport master (
    input  req, req_data, fifo_wr_ready,
    output ack, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output req, req_data, fifo_wr_ready,
    input  ack, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the shared FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-requester saturating beat counters (grant_cnt).
`ifdef FIFO_ARB_STATS_EN
module fifo_arb_stat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)                 cnt <= '0;
    else if (inc && !(&cnt))    cnt <= cnt + 1'b1;
endmodule
`endif

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  fifo_wr_arbiter_if.master   bus,
  output logic [NUM_REQ-1:0]  grant,
  output logic                busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt
`endif
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d, rr_q, rr_d, win;
  logic [BW-1:0]       beat_q, beat_d;
  logic [NUM_REQ-1:0]  grant_d, ack_w;
  logic                win_vld, own_req, own_ack, en_w;
  logic [DATA_WIDTH-1:0] data_w;

  // Descending scan so the closest set bit at or above rr_q is written last.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (bus.req[(int'(rr_q) + k) % NUM_REQ]) begin
        win     = IW'((int'(rr_q) + k) % NUM_REQ);
        win_vld = 1'b1;
      end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    grant_d = grant;
    ack_w   = '0;
    en_w    = 1'b0;
    data_w  = '0;
    own_req = bus.req[owner_q];
    own_ack = 1'b0;
    case (state_q)
      IDLE: if (win_vld) begin
        state_d = GRANT;
        owner_d = win;
        beat_d  = '0;
        grant_d = NUM_REQ'(1) << win;
      end
      GRANT: begin
        en_w           = own_req;
        own_ack        = own_req & bus.fifo_wr_ready;
        ack_w[owner_q] = own_ack;
        if (own_req) data_w = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        if (own_ack) beat_d = beat_q + 1'b1;
        // Burst limit reached or owner withdrew: one idle bubble, then re-arbitrate.
        if ((own_ack && beat_q == BW'(MAX_BURST-1)) || !own_req) begin
          state_d = IDLE;
          grant_d = '0;
          beat_d  = '0;
          rr_d    = (int'(owner_q) == NUM_REQ-1) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      grant   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      grant   <= grant_d;
    end
  end

  assign busy             = (state_q == GRANT);
  assign bus.ack          = ack_w;
  assign bus.fifo_wr_en   = en_w;
  assign bus.fifo_wr_data = data_w;

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    fifo_arb_stat_cnt #(.W(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ack_w[i]),
      .cnt   (grant_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level model of owner / burst count / round-robin pointer.
module tb_fifo_wr_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] grant;
  logic         busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // model: owner (-1 = idle), beats this grant, rr pointer, accepted beats
  int m_own, m_beats, m_rr;
  int m_acc [N];
  logic [N-1:0] m_ack;
  // observed DUT history for the hand-computed checks
  int dut_beats [N];
  int order [$];
  logic [N-1:0] prev_grant, s_grant, s_ack;
  logic s_en;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.fifo_wr_ready = 1'b0;
    m_own = -1; m_beats = 0; m_rr = 0; m_ack = '0;
    for (int i = 0; i < N; i++) begin m_acc[i] = 0; dut_beats[i] = 0; end
    order.delete();
    prev_grant = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: compare DUT against model, then advance the model across the edge.
  task automatic cycle();
    logic [N-1:0] eg, ea;
    logic ee;
    logic [DW-1:0] ed;
    int nown, nbeats, nrr;
    #1;
    eg = '0; ea = '0; ee = 1'b0; ed = '0;
    if (m_own >= 0) begin
      eg[m_own] = 1'b1;
      ee = bus.req[m_own];
      if (ee) ed = bus.req_data[m_own*DW +: DW];
      ea[m_own] = ee & bus.fifo_wr_ready;
    end
    check("grant",   grant, eg);
    check("busy",    busy, m_own >= 0);
    check("ack",     bus.ack, ea);
    check("wr_en",   bus.fifo_wr_en, ee);
    check("wr_data", bus.fifo_wr_data, ed);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check("grant_cnt", grant_cnt[i*CW +: CW], (m_acc[i] > MAXC) ? MAXC : m_acc[i]);
`endif
    s_grant = grant; s_ack = bus.ack; s_en = bus.fifo_wr_en;
    if (prev_grant == '0)
      for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
    prev_grant = grant;
    for (int i = 0; i < N; i++) if (bus.ack[i]) dut_beats[i]++;
    m_ack = ea;

    nown = m_own; nbeats = m_beats; nrr = m_rr;
    if (m_own < 0) begin
      for (int k = N-1; k >= 0; k--)
        if (bus.req[(m_rr + k) % N]) begin nown = (m_rr + k) % N; nbeats = 0; end
    end else if (!bus.req[m_own]) begin
      nown = -1; nrr = (m_own + 1) % N;
    end else if (bus.fifo_wr_ready) begin
      m_acc[m_own]++;
      nbeats = m_beats + 1;
      if (nbeats == MB) begin nown = -1; nrr = (m_own + 1) % N; end
    end
    @(posedge clk);
    m_own = nown; m_beats = nbeats; m_rr = nrr;
    @(negedge clk);
  endtask

  // Requesters hold req/data until acked, then may drop or present a new beat.
  task automatic rand_step();
    for (int i = 0; i < N; i++)
      if (!bus.req[i] || m_ack[i]) begin
        bus.req[i] = ($urandom_range(0, 2) != 0);
        bus.req_data[i*DW +: DW] = DW'($urandom);
      end
    bus.fifo_wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.req = '0; bus.req_data = '0; bus.fifo_wr_ready = 1'b0;
    #12;
    check("rst_grant", grant, 0);
    check("rst_busy",  busy, 0);
    check("rst_wr_en", bus.fifo_wr_en, 0);

    // single requester streaming: 4 beats per 5 cycles
    do_reset();
    bus.req = 4'b0010; bus.req_data[1*DW +: DW] = 8'h5A; bus.fifo_wr_ready = 1'b1;
    repeat (20) cycle();
    check("stream_beats", dut_beats[1], 16);
    check("stream_model_beats", m_acc[1], 16);
    check("stream_model_rr", m_rr, 2);

    // fairness with everyone requesting
    do_reset();
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'(8'h10 * (i + 1));
    bus.req = 4'b1111; bus.fifo_wr_ready = 1'b1;
    repeat (25) cycle();
    check("fair_len", order.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      if (k < order.size()) check("fair_order", order[k], k % N);
    check("fair_beats0", dut_beats[0], 8);
    check("fair_beats1", dut_beats[1], 4);

    // backpressure mid-burst on owner 2
    do_reset();
    bus.req = 4'b0100; bus.req_data[2*DW +: DW] = 8'hC2; bus.fifo_wr_ready = 1'b1;
    repeat (3) cycle();
    bus.fifo_wr_ready = 1'b0;
    repeat (3) begin
      cycle();
      check("bp_grant", s_grant, 4'b0100);
      check("bp_ack",   s_ack, 0);
      check("bp_en",    s_en, 1);
    end
    bus.fifo_wr_ready = 1'b1;
    cycle(); cycle();
    check("bp_beats", dut_beats[2], 4);
    cycle();
    check("bp_bubble", s_grant, 0);

    // early drop by owner 0 after one beat
    do_reset();
    bus.req = 4'b0001; bus.req_data[0 +: DW] = 8'hA0; bus.fifo_wr_ready = 1'b1;
    cycle(); cycle();
    bus.req = 4'b1000; bus.req_data[3*DW +: DW] = 8'hD3;
    cycle(); cycle(); cycle();
    check("drop_beats0", dut_beats[0], 1);
    check("drop_next",   s_grant, 4'b1000);

    // asynchronous reset in the middle of a burst
    do_reset();
    bus.req = 4'b0001; bus.req_data[0 +: DW] = 8'hA5; bus.fifo_wr_ready = 1'b1;
    cycle(); cycle();
    #1;
    check("mid_en_before", bus.fifo_wr_en, 1);
    reset = 1'b0;
    #1;
    check("mid_grant", grant, 0);
    check("mid_busy",  busy, 0);
    check("mid_en",    bus.fifo_wr_en, 0);
    check("mid_ack",   bus.ack, 0);
    do_reset();
    bus.req = 4'b0110; bus.fifo_wr_ready = 1'b1;
    cycle(); cycle();
    check("mid_first", s_grant, 4'b0010);

`ifdef FIFO_ARB_STATS_EN
    do_reset();
    bus.req = 4'b0001; bus.req_data[0 +: DW] = 8'h77; bus.fifo_wr_ready = 1'b1;
    repeat (26) cycle();
    check("stats_sat",    grant_cnt[0 +: CW], 15);
    check("stats_others", grant_cnt[N*CW-1:CW], 0);
`endif

    // random traffic
    do_reset();
    repeat (3000) begin
      rand_step();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
